clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Runtime-programmable integer clock divider producing a 50 %-duty output for both odd and even ratios, generalising the fixed divide-by-7 odd divider. It sits beside the clock source in the nowcoder utility set and generates slow derived clocks or enables from `clk_in`. New ratios are accepted through a write strobe and applied only at a period boundary, so no runt pulses appear. An optional enable-tick output provides a same-domain strobe for logic that must not use the divided clock.

## Interface
- `CNT_W`, 8: width of the divisor and the internal counter.
- `DIV_RST`, 7: active divisor after reset. Must satisfy 2 ≤ DIV_RST ≤ 2^CNT_W−1.
- `clk_in`  in  1  source clock; both edges are used.
- `rst`  in  1  reset, synchronous, active-low; clock clk_in.
- `en`  in  1  run request, sampled on posedge.
- `div_wr`  in  1  one-cycle strobe that captures `div_in`.
- `div_in`  in  CNT_W  requested ratio N.
- `div_busy`  out  1  a captured ratio is pending and not yet applied.
- `clk_out`  out  1  divided clock.
- `tick`  out  1  one-cycle pulse at the start of each output period. Present only with `CLK_DIV_TICK_EN`.

## Operation
- Registers:
  - `act_n`: active ratio.
  - `pend_n` with `pend_v`: pending ratio and its valid flag.
  - `cnt`: period counter.
  - `p`: posedge phase flop.
  - `n`: negedge flop.
  - `odd`: registered `act_n[0]`.
- Ratio clamping: a value below 2 (0 or 1) written on `div_in` is stored as 2.
- Define H = act_n >> 1.
- State machine:
  - IDLE: cnt=0, p=0. When en=1 is sampled, go to RUN with cnt←0, p←1.
  - RUN: cnt←(cnt==act_n−1) ? 0 : cnt+1. p←(cnt_next < H).
  - Wrap (cnt==act_n−1):
    - If pend_v, then act_n←pend_n, odd updates, and pend_v←0. The new H applies from cnt_next=0.
    - If en=0, go to IDLE with p←0.
- The negedge flop captures p: n←p on every negedge.
- Output: clk_out = odd ? (p | n) : p.
  - Odd N: high for (N−1)/2 + ½ cycles, low for the remainder.
  - Even N: high N/2 cycles, low N/2 cycles.
- `div_wr` handling:
  - pend_n←clamp(div_in), pend_v←1. A later write before the wrap overwrites the pending value; the last write wins.
  - If written in IDLE, the value applies immediately on the next posedge.
  - div_busy = pend_v.
- `tick` is registered and is high in the posedge cycle where p goes 0→1 (cnt_next=0).

## Timing
- Reset values: cnt=0, p=0, n=0, act_n=DIV_RST, pend_v=0. Outputs: clk_out=0, div_busy=0, tick=0.
- rst is also sampled at negedge by the n flop, so clk_out is low within one full clk_in cycle of rst asserting low.
- Startup latency: clk_out rises at the first posedge that samples en=1 with rst=1.
- Period is exactly act_n clk_in cycles. Ratio switches and odd/even mux changes occur only at p's rising edge, when n=0, so the output is glitch-free.
- Deasserting en mid-period completes the current period. clk_out then stays 0.
- div_wr and wrap in the same cycle: the old pend_n is applied, the new value becomes pending, and div_busy stays 1.
- Reset mid-period aborts the period with no completion and reloads DIV_RST.

## Configuration
- `CLK_DIV_TICK_EN` defined: the `tick` port and its flop exist.
- Not defined: the port is absent and no tick logic is synthesised. Clock output behaviour is identical in both cases.

## Structure
- Shared package `clk_div_pkg`:
  - `CLK_DIV_MIN` = 2.
  - state typedef {IDLE, RUN}.
  - clamp function.
- One natural sub-module, `clk_div_neg_stage`: the negedge flop with synchronous reset, kept separate so dual-edge timing constraints target it alone.

## Test plan
- Reset with DIV_RST=7, then en=1 → clk_out period 7 cycles, high 3.5 cycles, low 3.5 cycles; first rise at the first posedge after en sampled.
- div_in=4 written in IDLE, en=1 → high 2, low 2, period 4; tick every 4 cycles.
- Running at N=7, write div_in=4 at cnt=2 → the 7-cycle period completes; div_busy is high until the wrap; the next period is 4 cycles with no glitch (check all edges ≥1 cycle apart).
- Write div_in=0 and div_in=1 → both behave as N=2: 1 high, 1 low.
- At N=5, drop en at cnt=1 → the period finishes (high 2.5 cycles, low 2.5 cycles), then clk_out stays 0 and tick stops.
- Assert rst low mid-high-phase at N=9 → clk_out=0 within 1 cycle, div_busy=0; after release with en=1, period is 9 (DIV_RST reloaded if DIV_RST=9).

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types, limits and ratio clamp for the programmable clock divider
package clk_div_pkg;
  localparam int CLK_DIV_MIN = 2;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic logic [31:0] clamp(input logic [31:0] v);
    return v < 32'(CLK_DIV_MIN) ? 32'(CLK_DIV_MIN) : v;
  endfunction
endpackage

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control/status bundle of clk_div_prog; tick exists only with CLK_DIV_TICK_EN
interface clk_div_prog_if #(parameter int CNT_W = 8);
  logic en, div_wr, div_busy, clk_out;
  logic [CNT_W-1:0] div_in;
`ifdef CLK_DIV_TICK_EN
  logic tick;
  modport master(output en, div_wr, div_in, input div_busy, clk_out, tick);
  modport slave(input en, div_wr, div_in, output div_busy, clk_out, tick);
`else
  modport master(output en, div_wr, div_in, input div_busy, clk_out);
  modport slave(input en, div_wr, div_in, output div_busy, clk_out);
`endif
endinterface

// File: rtl/clk_div_neg_stage.sv
// clk_div_neg_stage: negedge retiming flop of the divider phase, isolated for dual-edge constraints
module clk_div_neg_stage (
  input  logic clk_in,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic n_q;
  always_ff @(negedge clk_in)
    if (!rst) n_q <= 1'b0;
    else n_q <= d_i;
  assign q_o = n_q;
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable 50%-duty integer clock divider
// define CLK_DIV_TICK_EN to add the same-domain period-start tick
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DIV_RST = 7
) (
  input logic clk_in,
  input logic rst,
  clk_div_prog_if.slave bus
);
  localparam logic [CNT_W-1:0] N_RST = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] act_n_q, act_n_d, pend_n_q, pend_n_d, cnt_q, cnt_d, act_h;
  logic pend_v_q, pend_v_d, p_q, p_d, odd_q, odd_d, n_q, wrap, apply;
  always_ff @(posedge clk_in)
    if (!rst) begin
      state_q <= IDLE;
      act_n_q <= N_RST;
      pend_n_q <= N_RST;
      pend_v_q <= 1'b0;
      cnt_q <= '0;
      p_q <= 1'b0;
      odd_q <= N_RST[0];
    end else begin
      state_q <= state_d;
      act_n_q <= act_n_d;
      pend_n_q <= pend_n_d;
      pend_v_q <= pend_v_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
      odd_q <= odd_d;
    end
  // ratio changes land only where p rises and n is low, so the odd/even mux cannot glitch
  always_comb begin
    wrap = state_q == RUN && cnt_q == act_n_q - ONE;
    apply = pend_v_q && (wrap || state_q == IDLE);
    state_d = state_q == IDLE ? (bus.en ? RUN : IDLE) : (wrap && !bus.en ? IDLE : RUN);
    act_n_d = apply ? pend_n_q : act_n_q;
    odd_d = act_n_d[0];
    act_h = act_n_d >> 1;
    pend_n_d = bus.div_wr ? CNT_W'(clamp(32'(bus.div_in))) : pend_n_q;
    pend_v_d = bus.div_wr || (pend_v_q && !apply);
    cnt_d = state_q == RUN && !wrap ? cnt_q + ONE : '0;
    p_d = state_d == RUN && cnt_d < act_h;
  end
  clk_div_neg_stage u_neg (.clk_in(clk_in), .rst(rst), .d_i(p_q), .q_o(n_q));
  always_comb begin
    bus.clk_out = odd_q ? p_q | n_q : p_q;
    bus.div_busy = pend_v_q;
  end
`ifdef CLK_DIV_TICK_EN
  logic tick_q;
  always_ff @(posedge clk_in) tick_q <= rst && p_d && !p_q;
  assign bus.tick = tick_q;
`endif
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: randomized self-checking bench for clk_div_prog against a half-cycle waveform model
module tb_clk_div_prog;
  localparam int DIV_RST = 7;
  logic clk_in = 1'b0;
  logic rst = 1'b0;
  clk_div_prog_if #(.CNT_W(8)) bus();
  clk_div_prog #(.CNT_W(8), .DIV_RST(DIV_RST)) dut (.clk_in(clk_in), .rst(rst), .bus(bus));
  always #5 clk_in = ~clk_in;
  int vectors = 0, miscompares = 0, cyc_n = 0;
  int m_n = DIV_RST, m_pn = DIV_RST, m_age = 0;
  bit m_run = 0, m_pv = 0, m_tick = 0, prev_r = 0;
  logic [3:0] obs, exp_v, msk;
  int glitch_cnt = 0;
  bit glitch_on = 0;
  time last_edge = 0;
  always @(bus.clk_out)
    if (glitch_on) begin
      if ($time - last_edge < 10) glitch_cnt++;
      last_edge = $time;
    end
  // Model: a period of N cycles is N half-cycles high then N half-cycles low; a new period
  // (and any pending ratio) may start only when idle or on the last cycle of the current one.
  task automatic cyc(input bit e, input bit w, input int d, input bit r);
    bus.en = e;
    bus.div_wr = w;
    bus.div_in = 8'(d);
    rst = r;
    @(posedge clk_in);
    #1;
    m_tick = 0;
    if (!r) begin
      m_run = 0; m_n = DIV_RST; m_pv = 0; m_age = 0;
    end else begin
      if (!m_run || m_age == m_n - 1) begin
        if (m_pv) begin m_n = m_pn; m_pv = 0; end
        m_run = e; m_age = 0; m_tick = e;
      end else m_age++;
      if (w) begin m_pn = d < 2 ? 2 : d; m_pv = 1; end
    end
    msk = (prev_r && !r) ? 4'b0111 : 4'b1111;
    prev_r = r;
    exp_v = {m_run && 2 * m_age < m_n, m_run && 2 * m_age + 1 < m_n, m_pv, m_tick};
`ifdef CLK_DIV_TICK_EN
    obs[0] = bus.tick;
`else
    obs[0] = 1'b0;
    msk[0] = 1'b0;
`endif
    obs[3] = bus.clk_out;
    obs[1] = bus.div_busy;
    @(negedge clk_in);
    #1;
    obs[2] = bus.clk_out;
    cyc_n++;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(i[0], 1'b1, 5, 0);
      vectors++;
      if ((obs & msk) !== (exp_v & msk)) begin miscompares++; $display("FAIL reset cyc=%0d got=%b want=%b", cyc_n, obs & msk, exp_v & msk); end
    end
  endtask
  task automatic test_div7();
    for (int i = 0; i < 22; i++) begin
      cyc(1, 0, 0, 1);
      vectors++;
      if ((obs & msk) !== (exp_v & msk)) begin miscompares++; $display("FAIL div7 cyc=%0d got=%b want=%b", cyc_n, obs & msk, exp_v & msk); end
    end
  endtask
  task automatic test_div4_idle();
    for (int i = 0; i < 300 && m_run; i++) cyc(0, 0, 0, 1);
    for (int i = 0; i < 18; i++) begin
      cyc(i >= 2, i == 0, 4, 1);
      vectors++;
      if ((obs & msk) !== (exp_v & msk)) begin miscompares++; $display("FAIL div4_idle cyc=%0d got=%b want=%b", cyc_n, obs & msk, exp_v & msk); end
    end
  endtask
  task automatic test_switch();
    bit done = 0, w;
    for (int i = 0; i < 300 && m_run; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 7, 1);
    cyc(0, 0, 0, 1);
    glitch_cnt = 0;
    last_edge = $time - 10;
    glitch_on = 1;
    for (int i = 0; i < 30; i++) begin
      w = m_run && m_n == 7 && m_age == 2 && !done;
      cyc(1, w, 4, 1);
      done |= w;
      vectors++;
      if ((obs & msk) !== (exp_v & msk)) begin miscompares++; $display("FAIL switch cyc=%0d got=%b want=%b", cyc_n, obs & msk, exp_v & msk); end
    end
    glitch_on = 0;
    vectors++;
    if (glitch_cnt != 0 || !done) begin miscompares++; $display("FAIL switch_glitch short_pulses=%0d required=0 write_done=%0d", glitch_cnt, done); end
  endtask
  task automatic test_clamp();
    for (int i = 0; i < 300 && m_run; i++) cyc(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(i >= 1, i == 0 || i == 8, i == 0 ? 0 : 1, 1);
      vectors++;
      if ((obs & msk) !== (exp_v & msk)) begin miscompares++; $display("FAIL clamp cyc=%0d got=%b want=%b", cyc_n, obs & msk, exp_v & msk); end
    end
  endtask
  task automatic test_en_drop();
    for (int i = 0; i < 300 && m_run; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 5, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(i < 7, 0, 0, 1);
      vectors++;
      if ((obs & msk) !== (exp_v & msk)) begin miscompares++; $display("FAIL en_drop cyc=%0d got=%b want=%b", cyc_n, obs & msk, exp_v & msk); end
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 300 && m_run; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 9, 1);
    for (int i = 0; i < 26; i++) begin
      cyc(1, i == 1, 3, !(i == 3 || i == 4));
      vectors++;
      if ((obs & msk) !== (exp_v & msk)) begin miscompares++; $display("FAIL reset_mid cyc=%0d got=%b want=%b", cyc_n, obs & msk, exp_v & msk); end
    end
  endtask
  task automatic test_wrap_write();
    bit s1 = 0, s2 = 0, w1, w2;
    for (int i = 0; i < 300 && m_run; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 3, 1);
    for (int i = 0; i < 24; i++) begin
      w1 = m_run && m_age == 0 && !s1;
      w2 = s1 && !s2 && m_age == m_n - 1;
      cyc(1, w1 || w2, w2 ? 6 : 5, 1);
      s1 |= w1;
      s2 |= w2;
      vectors++;
      if ((obs & msk) !== (exp_v & msk)) begin miscompares++; $display("FAIL wrap_write cyc=%0d got=%b want=%b", cyc_n, obs & msk, exp_v & msk); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 15), $urandom_range(0, 199) != 0);
      vectors++;
      if ((obs & msk) !== (exp_v & msk)) begin miscompares++; $display("FAIL random cyc=%0d got=%b want=%b", cyc_n, obs & msk, exp_v & msk); end
    end
  endtask
  initial begin
    bus.en = 1'b0;
    bus.div_wr = 1'b0;
    bus.div_in = '0;
    @(negedge clk_in);
    #1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    test_reset();
    test_div7();
    test_div4_idle();
    test_switch();
    test_clamp();
    test_en_drop();
    test_reset_mid();
    test_wrap_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
